ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
Sequencer for the RV32M multiply/divide unit that sits beside the ALU in the EX stage. It accepts one M-extension operation from EX and runs an iterative shift-add multiply or a restoring divide. While the operation is in flight it stalls EX. It then presents a one-cycle-registered result that EX muxes into alu_out. It also handles the RISC-V divide special cases and EX flush.

Parameters:
XLEN, 32, operand/result width (power of 2)
CNT_W, $clog2(XLEN), iteration counter width

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
mdu_req  input  1  EX holds a valid M-extension instruction
mdu_opcode  input  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
mdu_op1  input  XLEN  forwarded rs1 value
mdu_op2  input  XLEN  forwarded rs2 value
ex_flush  input  1  kill the in-flight operation
ex_hold  input  1  EX stalled by another source (LSU, hazard)
mdu_stall  output  1  stall request to the pipeline controller
mdu_busy  output  1  FSM not in IDLE
mdu_resp_valid  output  1  mdu_result valid for the instruction in EX
mdu_result  output  XLEN  result

Behaviour:
- Reset (rst low, async): state=IDLE, counter=0, mdu_resp_valid=0, mdu_result=0, internal accumulators=0; mdu_busy=0; mdu_stall=0 when mdu_req=0.
- mdu_stall = mdu_req & ~mdu_resp_valid & ~ex_flush (combinational). EX must keep opcode and operands stable while stalled.
- States:
  - IDLE: on mdu_req & ~ex_flush, latch the operand magnitudes, the sign flags and the opcode.
    - Special case (divide by zero, or DIV/REM with op1=0x80000000 and op2=-1): go to DONE.
    - Otherwise: go to CALC with counter=0.
  - CALC: one bit per cycle.
    - Multiply: 2*XLEN-bit shift-add on magnitudes.
    - Divide: restoring step on magnitudes.
    - When counter==XLEN-1, go to DONE. The final signed result is registered into mdu_result on that transition.
  - DONE: mdu_resp_valid=1.
    - If ex_hold=1, stay in DONE with the result held.
    - Else return to IDLE. EX advances this cycle, so the same instruction is never reissued.
- Latency, counted from the request cycle 0:
  - Special case: resp at cycle 1.
  - Normal operation: resp at cycle XLEN+1 (33).
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - MUL returns low XLEN bits; MULH* return high XLEN bits.
- Special results:
  - Divide by zero: DIV/DIVU quotient = all-ones; REM/REMU = op1.
  - Overflow: DIV = 0x80000000; REM = 0.
- ex_flush in any state: next state IDLE, mdu_resp_valid=0, counter cleared, no result produced. A flush wins over a simultaneous new request.
- mdu_req deasserting during CALC without a flush is illegal; assert it in simulation.
- mdu_resp_valid is never high for more than one cycle unless ex_hold=1.

Optional Feature:
MDU_FAST_MUL_EN.
- Defined: multiplies use a single-cycle XLEN×XLEN multiplier. IDLE goes to DONE with the product registered, so resp is at cycle 1. Divides are unchanged.
- Undefined: all multiplies are iterative with 33-cycle latency, and no hardware multiplier is inferred.

Decomposition:
- core.svh / core package:
  - mdu_opcode_e, with localparams equal to funct3 (MUL=3'b000 … REMU=3'b111).
  - mdu_state_e {IDLE, CALC, DONE}.
  - MDU_OP_RANGE macro.
- Sub-module mdu_iter_step: the combinational single-iteration datapath (shift-add step and restoring subtract step). ex_muldiv_ctrl owns the FSM, counter, sign fix-up and special cases.

Test Plan:
- DIVU 100/7 → stall for cycles 0–32; resp at cycle 33 with result 14; REMU returns 2.
- REM -7 % 2 → 0xFFFFFFFF (-1); DIV -7/2 → 0xFFFFFFFD (-3).
- DIV 5/0 → resp at cycle 1 with 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF; MUL → 1. With MDU_FAST_MUL_EN, each resp arrives at cycle 1.
- DIVU issued, ex_flush at cycle 10 → IDLE next cycle, no resp_valid. The following DIVU 9/3 → 3 at full latency.
- ex_hold=1 for 3 cycles in DONE → resp_valid and result held for 4 cycles, then IDLE; the next request is accepted exactly once.
- Reset asserted mid-CALC → all outputs 0 immediately (asynchronous), state IDLE.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// ex_muldiv_ctrl_pkg
// Shared types for the EX-stage multiply/divide sequencer.
//   mdu_opcode_e : M-extension funct3 encodings
//   mdu_state_e  : sequencer states
//   MDU_OP_RANGE : bit range of the opcode field, used on port declarations
// Optional build macro consumed by the top: MDU_FAST_MUL_EN.

`ifndef MDU_OP_RANGE
`define MDU_OP_RANGE 2:0
`endif

package ex_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdu_opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ex_muldiv_ctrl_iter_step.sv
// mdu_iter_step
// One iteration of the magnitude datapath, purely combinational.
//   is_div         : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_hi, acc_lo : multiply -> {partial product, remaining multiplier}
//                    divide   -> {partial remainder, dividend/quotient}
//   opb            : multiplicand or divisor magnitude
//   nxt_hi, nxt_lo : accumulator after this iteration

module mdu_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] sub_diff;

    assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    // The shifted remainder needs XLEN+1 bits; bit XLEN of the difference is the borrow.
    assign sub_diff = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opb};

    always_comb begin
        nxt_hi = add_sum[XLEN:1];
        nxt_lo = {add_sum[0], acc_lo[XLEN-1:1]};
        if (is_div) begin
            if (sub_diff[XLEN]) begin
                nxt_hi = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
            end else begin
                nxt_hi = sub_diff[XLEN-1:0];
                nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl
// RV32M multiply/divide sequencer beside the EX-stage ALU. Runs an iterative
// shift-add multiply or restoring divide on operand magnitudes, applies the
// sign fix-up, handles divide-by-zero / overflow, and stalls EX meanwhile.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   mdu_req         : EX holds a valid M instruction (stable while stalled)
//   mdu_opcode      : funct3
//   mdu_op1/op2     : forwarded rs1 / rs2
//   ex_flush        : kill in-flight operation
//   ex_hold         : EX stalled elsewhere; keep the result presented
//   mdu_stall       : stall request to the pipeline controller
//   mdu_busy        : sequencer not idle
//   mdu_resp_valid  : mdu_result belongs to the instruction in EX
//   mdu_result      : registered result
// Build macro: MDU_FAST_MUL_EN -> single-cycle multiplier, multiplies finish from IDLE.
//
// state | meaning
// IDLE  | waiting for a request; latches magnitudes, signs and opcode
// CALC  | one iteration per cycle, XLEN iterations
// DONE  | result presented; held while ex_hold

module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mdu_req,
    input  logic [`MDU_OP_RANGE] mdu_opcode,
    input  logic [XLEN-1:0]      mdu_op1,
    input  logic [XLEN-1:0]      mdu_op2,
    input  logic                 ex_flush,
    input  logic                 ex_hold,
    output logic                 mdu_stall,
    output logic                 mdu_busy,
    output logic                 mdu_resp_valid,
    output logic [XLEN-1:0]      mdu_result
);

    mdu_state_e  state, state_nxt;
    logic [CNT_W-1:0] cnt;
    mdu_opcode_e op_q;
    logic        res_neg_q, rem_neg_q;
    logic [XLEN-1:0] acc_hi, acc_lo, opb_q, result_q;
    logic [XLEN-1:0] step_hi, step_lo;

    mdu_opcode_e in_op;
    logic        in_div, a_signed, b_signed, a_neg, b_neg;
    logic        accept, div_zero, div_ovf, special, fast_mul, last_iter;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    assign in_op    = mdu_opcode_e'(mdu_opcode);
    assign in_div   = mdu_opcode[2];
    assign a_signed = (in_op == MUL) || (in_op == MULH) || (in_op == MULHSU) ||
                      (in_op == DIV) || (in_op == REM);
    assign b_signed = (in_op == MUL) || (in_op == MULH) || (in_op == DIV) || (in_op == REM);
    assign a_neg    = a_signed & mdu_op1[XLEN-1];
    assign b_neg    = b_signed & mdu_op2[XLEN-1];
    assign mag_a    = a_neg ? -mdu_op1 : mdu_op1;
    assign mag_b    = b_neg ? -mdu_op2 : mdu_op2;

    assign accept   = mdu_req & ~ex_flush;
    assign div_zero = in_div && (mdu_op2 == '0);
    assign div_ovf  = ((in_op == DIV) || (in_op == REM)) &&
                      (mdu_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_op2 == '1);
    assign special  = div_zero | div_ovf;
    assign last_iter = (cnt == CNT_W'(XLEN-1));

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = mag_a * mag_b;
    assign fast_mul  = ~in_div;
`else
    assign fast_mul  = 1'b0;
`endif

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = ((in_op == DIV) || (in_op == DIVU)) ? '1 : mdu_op1;
        else if (in_op == DIV)
            special_res = {1'b1, {(XLEN-1){1'b0}}};
    end

    // Magnitude result -> architectural result for the given opcode.
    function automatic logic [XLEN-1:0] fix_result(input mdu_opcode_e op,
                                                    input logic res_neg,
                                                    input logic rem_neg,
                                                    input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rmd;
        prod = res_neg ? -{hi, lo} : {hi, lo};
        quo  = res_neg ? -lo : lo;
        rmd  = rem_neg ? -hi : hi;
        case (op)
            MUL:                 return prod[XLEN-1:0];
            MULH, MULHSU, MULHU: return prod[2*XLEN-1:XLEN];
            DIV, DIVU:           return quo;
            default:             return rmd;
        endcase
    endfunction

    mdu_iter_step #(.XLEN(XLEN)) u_step (
        .is_div (op_q[2]),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opb    (opb_q),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (special || fast_mul) ? DONE : CALC;
            CALC: if (ex_flush) state_nxt = IDLE;
                  else if (last_iter) state_nxt = DONE;
            DONE: if (ex_flush || !ex_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_q      <= MUL;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q      <= in_op;
                    res_neg_q <= a_neg ^ b_neg;
                    rem_neg_q <= a_neg;
                    acc_hi    <= '0;
                    acc_lo    <= mag_a;
                    opb_q     <= mag_b;
                    cnt       <= '0;
                    if (special)
                        result_q <= special_res;
`ifdef MDU_FAST_MUL_EN
                    else if (fast_mul)
                        result_q <= fix_result(in_op, a_neg ^ b_neg, a_neg,
                                               fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
`endif
                end
                CALC: if (ex_flush) begin
                    cnt <= '0;
                end else begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (last_iter)
                        result_q <= fix_result(op_q, res_neg_q, rem_neg_q, step_hi, step_lo);
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign mdu_resp_valid = (state == DONE);
    assign mdu_busy       = (state != IDLE);
    assign mdu_stall      = mdu_req & ~mdu_resp_valid & ~ex_flush;
    assign mdu_result     = result_q;

    // EX must keep the instruction in place while iterating.
    a_req_held: assert property (@(posedge clk) disable iff (!rst)
                                 (state == CALC && !ex_flush) |-> mdu_req);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
module tb_ex_muldiv_ctrl;
    import ex_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mdu_req = 1'b0;
    logic [2:0]  mdu_opcode = 3'd0;
    logic [31:0] mdu_op1 = '0, mdu_op2 = '0;
    logic        ex_flush = 1'b0, ex_hold = 1'b0;
    logic        mdu_stall, mdu_busy, mdu_resp_valid;
    logic [31:0] mdu_result;

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .mdu_req(mdu_req), .mdu_opcode(mdu_opcode),
        .mdu_op1(mdu_op1), .mdu_op2(mdu_op2), .ex_flush(ex_flush), .ex_hold(ex_hold),
        .mdu_stall(mdu_stall), .mdu_busy(mdu_busy), .mdu_resp_valid(mdu_resp_valid),
        .mdu_result(mdu_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          hold;
        int          issue;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass = 0;
    int   held = 0;
    bit   prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h @cyc %0d", name, act, exp, cyc);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb_, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ub  = longint'({32'h0, b});
        case (op)
            MUL:    begin p = 64'(sa * sb_); return p[31:0]; end
            MULH:   begin p = 64'(sa * sb_); return p[63:32]; end
            MULHSU: begin p = 64'(sa * ub);  return p[63:32]; end
            MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb_); return p[31:0];
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb_); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MDU_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops one expectation per response, then tracks the hold window.
    always @(negedge clk) begin
        if (mdu_resp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp actual=%h required=no response", mdu_result);
            end else begin
                cur  = sb.pop_front();
                held = 0;
                check("result", mdu_result, cur.res);
                check("latency", 32'(cyc - cur.issue), 32'(cur.lat));
                check("stall_at_resp", 32'(mdu_stall), 32'd0);
            end
        end else if (mdu_resp_valid) begin
            held++;
            check("held_result", mdu_result, cur.res);
        end else if (prev_v) begin
            check("hold_len", 32'(held), 32'(cur.hold));
        end
        prev_v = mdu_resp_valid;
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        exp_t e;
        bit   got;
        int   bad_stall;
        e.res = model(op, a, b);
        e.lat = exp_lat(op, a, b);
        e.hold = hold;
        e.issue = cyc;
        sb.push_back(e);
        mdu_opcode = op; mdu_op1 = a; mdu_op2 = b; mdu_req = 1'b1;
        #1;
        check("stall_c0", 32'(mdu_stall), 32'd1);
        got = 1'b0;
        bad_stall = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            if (mdu_resp_valid) got = 1'b1;
            else begin
                if (!mdu_stall) bad_stall++;
                ex_hold = 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL resp_timeout actual=no response required=response op=%0d", op);
            mdu_req = 1'b0; ex_hold = 1'b0; rst = 1'b0;
            sb.delete();
            @(negedge clk); rst = 1'b1;
            @(negedge clk); #1;
            return;
        end
        check("stall_wait", 32'(bad_stall), 32'd0);
        ex_hold = 1'b0;
        if (hold > 0) begin
            ex_hold = 1'b1;
            repeat (hold) begin @(negedge clk); #1; end
        end
        ex_hold = 1'b0;
        mdu_req = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(mdu_busy), 32'd0);
        check("rst_valid", 32'(mdu_resp_valid), 32'd0);
        check("rst_result", mdu_result, 32'd0);
        check("rst_stall", 32'(mdu_stall), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;

        issue(DIVU, 32'd100, 32'd7, 0);
        issue(REMU, 32'd100, 32'd7, 0);
        issue(REM,  32'hFFFF_FFF9, 32'd2, 0);
        issue(DIV,  32'hFFFF_FFF9, 32'd2, 0);
        issue(DIV,  32'd5, 32'd0, 0);
        issue(REMU, 32'd5, 32'd0, 0);
        issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Flush in cycle 10 of a DIVU: no response may appear.
        mdu_opcode = DIVU; mdu_op1 = 32'd1000; mdu_op2 = 32'd3; mdu_req = 1'b1;
        repeat (10) begin @(negedge clk); #1; end
        ex_flush = 1'b1;
        #1;
        check("stall_flush", 32'(mdu_stall), 32'd0);
        @(negedge clk); #1;
        check("flush_busy", 32'(mdu_busy), 32'd0);
        check("flush_valid", 32'(mdu_resp_valid), 32'd0);
        ex_flush = 1'b0; mdu_req = 1'b0;
        @(negedge clk); #1;
        issue(DIVU, 32'd9, 32'd3, 0);

        issue(DIVU, 32'd77, 32'd5, 3);
        issue(DIV,  32'd5, 32'd0, 0);

        for (int i = 0; i < 40; i++)
            issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

        // Asynchronous reset in the middle of CALC.
        issue(DIVU, 32'd9, 32'd3, 0);
        mdu_opcode = DIVU; mdu_op1 = 32'd12345; mdu_op2 = 32'd11; mdu_req = 1'b1;
        repeat (5) begin @(negedge clk); #1; end
        check("busy_calc", 32'(mdu_busy), 32'd1);
        rst = 1'b0; mdu_req = 1'b0;
        #1;
        check("arst_busy", 32'(mdu_busy), 32'd0);
        check("arst_valid", 32'(mdu_resp_valid), 32'd0);
        check("arst_result", mdu_result, 32'd0);
        check("arst_stall", 32'(mdu_stall), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        repeat (5) @(negedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
